// File: rtl/dot_seq_pkg.sv
// Shared types and constants for the dot-product sequencer and its element-pair FIFO.
package dot_seq_pkg;

  localparam int ELEM_W       = 8;
  localparam int ACC_W        = 32;
  localparam int DRAIN_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    RESULT
  } seq_state_e;

  typedef struct packed {
    logic signed [ELEM_W-1:0] a;
    logic signed [ELEM_W-1:0] b;
  } elem_pair_t;

endpackage

// File: rtl/dot_seq_fifo.sv
// Synchronous element-pair FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module dot_seq_fifo
  import dot_seq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  elem_pair_t             wdata,
  output elem_pair_t             rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  elem_pair_t     mem_q [DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [AW:0]    count_q;
  logic           do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dot_product_sequencer.sv
// Command-driven feeder for the dot-product accelerator: buffers element pairs, streams N
// of them per command and returns the accumulator value. Define DOT_SEQ_PERF_CNT_EN for stall_cycles.
module dot_product_sequencer
  import dot_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LEN_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ELEM_W-1:0] load_a,
  input  logic [ELEM_W-1:0] load_b,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic [ELEM_W-1:0] acc_vector_a,
  output logic [ELEM_W-1:0] acc_vector_b,
  output logic              acc_start,
  output logic              acc_clear,
  input  logic [ACC_W-1:0]  acc_vector_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data
`ifdef DOT_SEQ_PERF_CNT_EN
  ,
  output logic [ACC_W-1:0]  stall_cycles
`endif
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  seq_state_e          state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [ELEM_W-1:0]   va_q, va_d, vb_q, vb_d;
  logic                start_q, start_d, clear_q, clear_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic                res_valid_q, res_valid_d;
  logic [ACC_W-1:0]    res_data_q, res_data_d;

  elem_pair_t          fifo_wdata, fifo_rdata;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  assign load_ready = (fifo_count < CNT_W'(DEPTH));
  assign fifo_push  = load_valid && !fifo_full;
  assign fifo_wdata = {load_a, load_b};

  dot_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    va_d        = va_q;
    vb_d        = vb_q;
    start_d     = 1'b0;
    clear_d     = 1'b0;
    drain_d     = drain_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rem_d   = cmd_len;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        clear_d = 1'b1;
        drain_d = '0;
        state_d = (rem_q != '0) ? STREAM : DRAIN;
      end
      STREAM: begin
        if (rem_q == '0) begin
          state_d = DRAIN;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          va_d     = fifo_rdata.a;
          vb_d     = fifo_rdata.b;
          start_d  = 1'b1;
          rem_d    = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      // First drain cycle presents the last pair; the last one sees its accumulated value.
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
          drain_d     = '0;
          res_data_d  = acc_vector_c;
          res_valid_d = 1'b1;
          state_d     = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      va_q        <= '0;
      vb_q        <= '0;
      start_q     <= 1'b0;
      clear_q     <= 1'b0;
      drain_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      va_q        <= va_d;
      vb_q        <= vb_d;
      start_q     <= start_d;
      clear_q     <= clear_d;
      drain_q     <= drain_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign acc_vector_a = va_q;
  assign acc_vector_b = vb_q;
  assign acc_start    = start_q;
  assign acc_clear    = clear_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;

`ifdef DOT_SEQ_PERF_CNT_EN
  logic             stall_cycle;
  logic [ACC_W-1:0] stall_q;

  assign stall_cycle = (state_q == STREAM) && (rem_q != '0) && fifo_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else if (state_q == IDLE && cmd_valid) begin
      stall_q <= '0;
    end else if (stall_cycle && stall_q != '1) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Self-checking bench for dot_product_sequencer: accelerator model, pair scoreboard and
// a pop-schedule reference that predicts acc_start timing, latency, result and stalls.
module tb_dot_product_sequencer;

  localparam int DEPTH = 16;
  localparam int LEN_W = 16;
  localparam int MAXR  = 200;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                load_valid = 1'b0;
  logic                load_ready;
  logic signed [7:0]   load_a = '0;
  logic signed [7:0]   load_b = '0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [LEN_W-1:0]    cmd_len = '0;
  logic signed [7:0]   acc_vector_a, acc_vector_b;
  logic                acc_start, acc_clear;
  logic [31:0]         acc_vector_c;
  logic                res_valid;
  logic                res_ready = 1'b0;
  logic [31:0]         res_data;
`ifdef DOT_SEQ_PERF_CNT_EN
  logic [31:0]         stall_cycles;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  dot_product_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_a       (load_a),
    .load_b       (load_b),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_len      (cmd_len),
    .acc_vector_a (acc_vector_a),
    .acc_vector_b (acc_vector_b),
    .acc_start    (acc_start),
    .acc_clear    (acc_clear),
    .acc_vector_c (acc_vector_c),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data)
`ifdef DOT_SEQ_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // Accelerator: registered accumulator, clear beats start; poke preloads a value.
  logic signed [31:0] acc_c = '0;
  logic               acc_poke = 1'b0;
  logic signed [31:0] acc_poke_val = '0;
  always @(posedge clock) begin
    if (acc_poke)       acc_c <= acc_poke_val;
    else if (acc_clear) acc_c <= '0;
    else if (acc_start) acc_c <= acc_c + acc_vector_a * acc_vector_b;
  end
  assign acc_vector_c = acc_c;

  // Cycle index: value seen during a cycle equals the number of rising edges so far.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int a; int b; int cyc; } ent_t;
  ent_t        pair_q[$];
  logic [15:0] pend_q[$];
  logic [31:0] exp_q[$];

  always @(negedge clock) begin
    ent_t e;
    if (reset) begin
      pair_q.delete();
    end else if (load_valid && load_ready) begin
      e.a = int'(load_a);
      e.b = int'(load_b);
      e.cyc = cyc;
      pair_q.push_back(e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_pair(input logic [7:0] pa, input logic [7:0] pb);
    int tmo = 0;
    @(posedge clock); #1;
    load_valid = 1'b1; load_a = pa; load_b = pb;
    @(negedge clock);
    while (!load_ready && tmo < 40) begin @(negedge clock); tmo++; end
    if (!load_ready) begin
      n_total++;
      $display("FAIL push_timeout: load_ready=%0b required 1", load_ready);
    end
  endtask

  task automatic load_idle();
    @(posedge clock); #1;
    load_valid = 1'b0;
  endtask

  task automatic do_cmd(input int len, input int gap, input int hold, input string tag,
                        input bit use_want, input int want);
    int a_cyc, r, rv, tmo, t_prev, t, exp_rv, exp_stall, exp_sum, lim;
    logic st_obs [MAXR+1];
    logic cl_obs [MAXR+1];
    logic cr_obs [MAXR+1];
    logic exp_st [MAXR+8];
    logic [31:0] exp_res;
    ent_t e;
    for (int i = 0; i < MAXR + 8; i++) exp_st[i] = 1'b0;
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_len = LEN_W'(len);
    @(negedge clock);
    tmo = 0;
    while (!cmd_ready && tmo < 50) begin @(negedge clock); tmo++; end
    if (!cmd_ready) begin
      n_total++;
      $display("FAIL %s accept_timeout: cmd_ready=%0b required 1", tag, cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    a_cyc = cyc;
    rv = 0; r = 0;
    while (rv == 0 && r < MAXR) begin
      @(posedge clock); #1;
      r++;
      cmd_valid = 1'b0;
      if (gap > 0 && pend_q.size() > 0 && (r % gap) == 0) begin
        load_valid = 1'b1;
        {load_a, load_b} = pend_q[0];
      end else begin
        load_valid = 1'b0;
      end
      @(negedge clock);
      if (load_valid && load_ready) void'(pend_q.pop_front());
      st_obs[r] = acc_start; cl_obs[r] = acc_clear; cr_obs[r] = cmd_ready;
      if (res_valid) rv = r;
    end
    load_valid = 1'b0;

    // Reference: pair k pops at the first cycle after CLEAR, after its push, after pop k-1.
    t_prev = a_cyc + 1; exp_sum = 0;
    for (int k = 0; k < len; k++) begin
      if (pair_q.size() == 0) begin
        n_total++;
        $display("FAIL %s model_underflow: pairs=%0d required %0d", tag, k, len);
        break;
      end
      e = pair_q.pop_front();
      t = (e.cyc + 1 > t_prev + 1) ? e.cyc + 1 : t_prev + 1;
      if (t + 1 - a_cyc <= MAXR) exp_st[t + 1 - a_cyc] = 1'b1;
      exp_sum += e.a * e.b;
      t_prev = t;
    end
    exp_rv    = t_prev + 3 - a_cyc;
    exp_stall = t_prev - a_cyc - 1 - len;
    exp_q.push_back(32'(exp_sum));

    n_total++;
    if (rv !== exp_rv) $display("FAIL %s latency: got %0d required %0d", tag, rv, exp_rv);
    else n_pass++;
    lim = (rv < exp_rv) ? rv : exp_rv;
    for (int i = 1; i <= lim; i++) begin
      n_total++;
      if ({st_obs[i], cl_obs[i], cr_obs[i]} !== {exp_st[i], (i == 2), 1'b0})
        $display("FAIL %s cycle%0d start/clear/cmd_ready: got %b%b%b required %b%b0",
                 tag, i, st_obs[i], cl_obs[i], cr_obs[i], exp_st[i], (i == 2));
      else n_pass++;
    end
    exp_res = exp_q.pop_front();
    if (rv == 0) return;

    n_total++;
    if (res_data !== exp_res) $display("FAIL %s res_data: got %0d required %0d", tag, $signed(res_data), $signed(exp_res));
    else n_pass++;
    if (use_want) begin
      n_total++;
      if (res_data !== 32'(want)) $display("FAIL %s res_const: got %0d required %0d", tag, $signed(res_data), want);
      else n_pass++;
    end
`ifdef DOT_SEQ_PERF_CNT_EN
    n_total++;
    if (stall_cycles !== 32'(exp_stall)) $display("FAIL %s stall_cycles: got %0d required %0d", tag, stall_cycles, exp_stall);
    else n_pass++;
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      res_ready = 1'b0;
      @(negedge clock);
      n_total++;
      if ({res_valid, cmd_ready, res_data} !== {1'b1, 1'b0, exp_res})
        $display("FAIL %s hold%0d valid/cmd_ready/data: got %b/%b/%0d required 1/0/%0d",
                 tag, h, res_valid, cmd_ready, $signed(res_data), $signed(exp_res));
      else n_pass++;
    end
    @(posedge clock); #1;
    res_ready = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    res_ready = 1'b0;
    @(negedge clock);
    n_total++;
    if ({res_valid, cmd_ready} !== 2'b01)
      $display("FAIL %s consume: res_valid/cmd_ready got %b%b required 01", tag, res_valid, cmd_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_total++;
    if ({load_ready, cmd_ready, acc_start, acc_clear, res_valid} !== 5'b11000)
      $display("FAIL reset_ctrl: got %b required 11000", {load_ready, cmd_ready, acc_start, acc_clear, res_valid});
    else n_pass++;
    n_total++;
    if ({acc_vector_a, acc_vector_b, res_data} !== 48'd0)
      $display("FAIL reset_data: a=%0d b=%0d res=%0d required 0", acc_vector_a, acc_vector_b, res_data);
    else n_pass++;
`ifdef DOT_SEQ_PERF_CNT_EN
    n_total++;
    if (stall_cycles !== 32'd0) $display("FAIL reset_stall: got %0d required 0", stall_cycles);
    else n_pass++;
`endif
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    push_pair(8'd1, 8'd4); push_pair(8'd2, 8'd5); push_pair(8'd3, 8'd6);
    load_idle();
    do_cmd(3, 0, 0, "basic", 1'b1, 32);
  endtask

  task automatic test_signed_extremes();
    push_pair(8'h80, 8'h80); push_pair(8'h80, 8'h7f);
    load_idle();
    do_cmd(2, 0, 1, "signed", 1'b1, 128);
  endtask

  task automatic test_zero_len();
    push_pair(8'd5, 8'd5);
    load_idle();
    @(posedge clock); #1;
    acc_poke = 1'b1; acc_poke_val = 32'sd99;
    @(posedge clock); #1;
    acc_poke = 1'b0;
    do_cmd(0, 0, 0, "zero_len", 1'b1, 0);
    do_cmd(1, 0, 0, "after_zero", 1'b1, 25);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) pend_q.push_back(16'h0101);
    do_cmd(4, 3, 0, "stall", 1'b1, 4);
  endtask

  task automatic test_full_backpressure();
    for (int i = 0; i < DEPTH; i++) push_pair(8'd1, 8'd2);
    @(posedge clock); #1;
    load_a = 8'sd3; load_b = 8'sd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_total++;
      if (load_ready !== 1'b0) $display("FAIL full_load_ready%0d: got %b required 0", i, load_ready);
      else n_pass++;
    end
    @(posedge clock); #1;
    load_valid = 1'b0;
    do_cmd(DEPTH, 0, 5, "full", 1'b1, 2 * DEPTH);
  endtask

  task automatic test_reset_mid_stream();
    for (int i = 0; i < 5; i++) push_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    load_idle();
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_len = LEN_W'(5);
    @(negedge clock);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    @(negedge clock);
    @(posedge clock); #1;
    @(negedge clock);
    n_total++;
    if (acc_clear !== 1'b1) $display("FAIL rst_mid_clear: got %b required 1", acc_clear);
    else n_pass++;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    n_total++;
    if (acc_start !== 1'b1) $display("FAIL rst_mid_streaming: acc_start got %b required 1", acc_start);
    else n_pass++;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    n_total++;
    if ({load_ready, cmd_ready, acc_start, acc_clear, res_valid, acc_vector_a, acc_vector_b} !== {5'b11000, 16'd0})
      $display("FAIL rst_mid_state: ctrl=%b a=%0d b=%0d required 11000 0 0",
               {load_ready, cmd_ready, acc_start, acc_clear, res_valid}, acc_vector_a, acc_vector_b);
    else n_pass++;
    push_pair(8'd7, 8'd7);
    load_idle();
    do_cmd(1, 0, 0, "after_reset", 1'b1, 49);
  endtask

  task automatic test_random();
    int pre, len, gap, hold;
    for (int it = 0; it < 4; it++) begin
      pre  = $urandom_range(0, 3);
      len  = $urandom_range(0, 6);
      gap  = $urandom_range(1, 3);
      hold = $urandom_range(0, 2);
      for (int i = 0; i < pre; i++) push_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      if (pre > 0) load_idle();
      for (int i = 0; i < len - pre; i++) pend_q.push_back(16'($urandom_range(0, 65535)));
      do_cmd(len, gap, hold, "random", 1'b0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed_extremes();
    test_zero_len();
    test_stall();
    test_full_backpressure();
    test_reset_mid_stream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
